// File: rtl/ram64_copy_engine.sv
// rtl/ram64_copy_engine.sv - block COPY/FILL initiator driving the single port of a 64x16 RAM
module ram64_copy_engine #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W:0]   len,
  input  logic [WIDTH-1:0]  fill_val,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic [WIDTH-1:0]  mem_in,
  output logic              mem_load,
  input  logic [WIDTH-1:0]  mem_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1) << ADDR_W;

  state_t            state, state_nxt;
  logic              mode_q;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [ADDR_W-1:0] last_q;
  logic [ADDR_W-1:0] i_q;
  logic [WIDTH-1:0]  fill_q;
  logic [WIDTH-1:0]  data_q;
  logic [ADDR_W-1:0] addr_hold;
  logic [WIDTH-1:0]  din_hold;
  logic [ADDR_W-1:0] last_nxt;
  logic              launch;

  // Store the index of the final word; oversize lengths clamp to the full RAM.
  assign last_nxt = (len >= DEPTH) ? {ADDR_W{1'b1}} : len[ADDR_W-1:0] - ADDR_W'(1);
  assign launch   = (state == S_IDLE) && start;

  always_comb begin
    state_nxt   = state;
    busy        = 1'b0;
    done        = 1'b0;
    mem_load    = 1'b0;
    mem_address = addr_hold;
    mem_in      = din_hold;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (len == '0)
            state_nxt = S_DONE;
          else if (mode)
            state_nxt = S_WRITE;
          else
            state_nxt = S_READ;
        end
      end
      S_READ: begin
        busy        = 1'b1;
        mem_address = src_q + i_q;
        state_nxt   = S_WRITE;
      end
      S_WRITE: begin
        busy        = 1'b1;
        mem_load    = 1'b1;
        mem_address = dst_q + i_q;
        mem_in      = mode_q ? fill_q : data_q;
        if (i_q == last_q)
          state_nxt = S_DONE;
        else if (mode_q)
          state_nxt = S_WRITE;
        else
          state_nxt = S_READ;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      mode_q    <= 1'b0;
      src_q     <= '0;
      dst_q     <= '0;
      last_q    <= '0;
      i_q       <= '0;
      fill_q    <= '0;
      data_q    <= '0;
      addr_hold <= '0;
      din_hold  <= '0;
    end else begin
      state     <= state_nxt;
      // Address and write data hold their last driven value once idle.
      addr_hold <= mem_address;
      din_hold  <= mem_in;
      if (launch) begin
        mode_q <= mode;
        src_q  <= src;
        dst_q  <= dst;
        last_q <= last_nxt;
        fill_q <= fill_val;
        i_q    <= '0;
      end
      if (state == S_READ)
        data_q <= mem_out;
      if ((state == S_WRITE) && (i_q != last_q))
        i_q <= i_q + ADDR_W'(1);
    end
  end

endmodule

// File: tb/tb_ram64_copy_engine.sv
// tb/tb_ram64_copy_engine.sv - self-checking bench for ram64_copy_engine with a RAM model and write scoreboard
module tb_ram64_copy_engine;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        mode;
  logic [5:0]  src;
  logic [5:0]  dst;
  logic [6:0]  len;
  logic [15:0] fill_val;
  logic        busy;
  logic        done;
  logic [5:0]  mem_address;
  logic [15:0] mem_in;
  logic        mem_load;
  logic [15:0] mem_out;

  typedef struct {
    logic        mode;
    logic [5:0]  src;
    logic [5:0]  dst;
    logic [6:0]  len;
    logic [15:0] fill;
    int          lat;
  } vec_t;

  typedef struct {
    logic [5:0]  a;
    logic [15:0] d;
  } wr_t;

  logic [15:0] ram [64];
  logic [15:0] sh  [64];
  logic        pre_we = 1'b0;
  logic [5:0]  pre_addr = '0;
  logic [15:0] pre_data = '0;
  wr_t         exp_q[$];
  vec_t        vecs[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          nload = 0;

  always #5 clk = ~clk;

  ram64_copy_engine #(.WIDTH(16), .ADDR_W(6)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .src(src), .dst(dst),
    .len(len), .fill_val(fill_val), .busy(busy), .done(done), .mem_address(mem_address),
    .mem_in(mem_in), .mem_load(mem_load), .mem_out(mem_out)
  );

  assign mem_out = ram[mem_address];

  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (mem_load) ram[mem_address] <= mem_in;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every RAM write the DUT issues must match the next expected write.
  always @(negedge clk) begin
    if (reset_n && mem_load) begin
      nload++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: addr %0d data %0h, expected no write", mem_address, mem_in);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check("write_addr", 32'(mem_address), 32'(w.a));
        check("write_data", 32'(mem_in), 32'(w.d));
      end
    end
  end

  // Reference model: ascending word order, each word read right before its write.
  task automatic model_push(input logic m, input int s, input int d, input int l, input logic [15:0] f);
    int n;
    logic [15:0] v;
    wr_t w;
    n = (l > 64) ? 64 : l;
    for (int i = 0; i < n; i++) begin
      v = m ? f : sh[(s + i) % 64];
      sh[(d + i) % 64] = v;
      w.a = 6'((d + i) % 64);
      w.d = v;
      exp_q.push_back(w);
    end
  endtask

  task automatic preload(input int k, input logic [15:0] v);
    @(negedge clk);
    pre_we = 1'b1;
    pre_addr = 6'(k);
    pre_data = v;
    @(posedge clk);
    #1 pre_we = 1'b0;
    sh[k] = v;
  endtask

  task automatic image_check(input string name);
    int bad = 0;
    for (int k = 0; k < 64; k++)
      if (ram[k] !== sh[k]) bad++;
    check(name, 32'(bad), 32'd0);
  endtask

  task automatic run_xfer(input vec_t v, input string name);
    int c = 0;
    int bc = 0;
    int n0;
    logic got = 1'b0;
    @(negedge clk);
    mode = v.mode; src = v.src; dst = v.dst; len = v.len; fill_val = v.fill; start = 1'b1;
    model_push(v.mode, int'(v.src), int'(v.dst), int'(v.len), v.fill);
    n0 = nload;
    @(posedge clk);
    #1 start = 1'b0;
    while (c < 300 && !got) begin
      @(negedge clk);
      c++;
      if (busy) bc++;
      if (done) got = 1'b1;
      // Operand changes while busy must not matter.
      mode = 1'($urandom); src = 6'($urandom); dst = 6'($urandom);
      len = 7'($urandom); fill_val = 16'($urandom);
    end
    check({name, "_latency"}, 32'(c), 32'(v.lat));
    check({name, "_busy_cycles"}, 32'(bc), 32'(v.lat - 1));
    check({name, "_loads"}, 32'(nload - n0), 32'((v.len > 64) ? 64 : v.len));
    @(negedge clk);
    check({name, "_done_one_cycle"}, 32'(done), 32'd0);
    check({name, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    image_check({name, "_ram_image"});
  endtask

  initial begin
    vec_t v;
    int nd, bc, nl, c;
    reset_n = 1'b0; start = 1'b0; mode = 1'b0; src = '0; dst = '0; len = '0; fill_val = '0;

    vecs.push_back('{mode: 1'b1, src: 6'd0,  dst: 6'd10, len: 7'd5,   fill: 16'hBEEF, lat: 6});
    vecs.push_back('{mode: 1'b0, src: 6'd0,  dst: 6'd32, len: 7'd8,   fill: 16'h0000, lat: 17});
    vecs.push_back('{mode: 1'b0, src: 6'd60, dst: 6'd2,  len: 7'd8,   fill: 16'h0000, lat: 17});
    vecs.push_back('{mode: 1'b1, src: 6'd0,  dst: 6'd0,  len: 7'd64,  fill: 16'hA5A5, lat: 65});
    vecs.push_back('{mode: 1'b0, src: 6'd3,  dst: 6'd9,  len: 7'd0,   fill: 16'h0000, lat: 1});
    vecs.push_back('{mode: 1'b0, src: 6'd20, dst: 6'd33, len: 7'd4,   fill: 16'h0000, lat: 9});
    vecs.push_back('{mode: 1'b0, src: 6'd5,  dst: 6'd5,  len: 7'd4,   fill: 16'h0000, lat: 9});
    vecs.push_back('{mode: 1'b1, src: 6'd0,  dst: 6'd7,  len: 7'd100, fill: 16'h0F0F, lat: 65});

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_load", 32'(mem_load), 32'd0);
    check("reset_addr", 32'(mem_address), 32'd0);
    check("reset_din", 32'(mem_in), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int k = 0; k < 64; k++) preload(k, 16'($urandom));
    for (int k = 0; k < 8; k++) preload(k, 16'h0100 + 16'(k));

    for (int t = 0; t < vecs.size(); t++) begin
      if (t == 3) begin
        // Re-seed the RAM after the wrap test so the full fill starts from fresh data.
        for (int k = 60; k < 64; k++) preload(k, 16'($urandom));
      end
      run_xfer(vecs[t], $sformatf("vec%0d", t));
    end

    for (int k = 32; k < 40; k++) sh[k] = sh[k];
    check("copy_word32", 32'(ram[32]), 32'h0 + 32'(sh[32]));

    // Overlapping copy replicates the first word.
    preload(0, 16'hAAAA); preload(1, 16'hBBBB); preload(2, 16'hCCCC); preload(3, 16'hDDDD);
    v = '{mode: 1'b0, src: 6'd0, dst: 6'd1, len: 7'd3, fill: 16'h0, lat: 7};
    run_xfer(v, "overlap");
    check("overlap_w1", 32'(ram[1]), 32'hAAAA);
    check("overlap_w2", 32'(ram[2]), 32'hAAAA);
    check("overlap_w3", 32'(ram[3]), 32'hAAAA);

    // start held for 10 cycles across a 13-cycle copy launches only once.
    @(negedge clk);
    mode = 1'b0; src = 6'd0; dst = 6'd20; len = 7'd6; start = 1'b1;
    model_push(1'b0, 0, 20, 6, 16'h0);
    nd = 0; bc = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (k == 9) start = 1'b0;
      if (done) nd++;
      if (busy) bc++;
    end
    check("held_start_done_count", 32'(nd), 32'd1);
    check("held_start_busy_cycles", 32'(bc), 32'd12);
    check("held_start_queue", 32'(exp_q.size()), 32'd0);
    image_check("held_start_ram_image");

    // start in the DONE cycle is ignored; start in the next IDLE cycle launches.
    @(negedge clk);
    mode = 1'b1; dst = 6'd44; len = 7'd2; fill_val = 16'h5A5A; start = 1'b1;
    model_push(1'b1, 0, 44, 2, 16'h5A5A);
    @(posedge clk);
    #1 start = 1'b0;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!done && c < 20);
    check("done_cycle_latency", 32'(c), 32'd3);
    mode = 1'b1; dst = 6'd50; len = 7'd1; fill_val = 16'h1234; start = 1'b1;
    model_push(1'b1, 0, 50, 1, 16'h1234);
    @(negedge clk);
    check("start_in_done_ignored", 32'(busy), 32'd0);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("start_in_idle_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("start_in_idle_done", 32'(done), 32'd1);
    check("start_in_idle_queue", 32'(exp_q.size()), 32'd0);
    check("start_in_idle_word", 32'(ram[50]), 32'h1234);
    image_check("handshake_ram_image");

    // Asynchronous reset during the fourth write of a copy.
    @(negedge clk);
    mode = 1'b0; src = 6'd0; dst = 6'd40; len = 7'd8; start = 1'b1;
    model_push(1'b0, 0, 40, 3, 16'h0);
    @(posedge clk);
    #1 start = 1'b0;
    nl = 0;
    for (int k = 0; k < 40 && nl < 4; k++) begin
      @(posedge clk);
      #1;
      if (mem_load) nl++;
    end
    check("abort_reached_i3", 32'(nl), 32'd4);
    reset_n = 1'b0;
    #1;
    check("abort_load_async", 32'(mem_load), 32'd0);
    check("abort_busy_async", 32'(busy), 32'd0);
    check("abort_addr_async", 32'(mem_address), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("abort_idle_busy", 32'(busy), 32'd0);
    check("abort_idle_done", 32'(done), 32'd0);
    check("abort_queue", 32'(exp_q.size()), 32'd0);
    image_check("abort_ram_image");
    v = '{mode: 1'b1, src: 6'd0, dst: 6'd0, len: 7'd0, fill: 16'h0, lat: 1};
    run_xfer(v, "post_abort_len0");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
